rvfi_retire_sequencer: RTL

//  Scheduler between a multi-channel RVFI retirement port and the single-channel register checker.

---
 rtl/rvfi_seq_pkg.sv | 23 ++
 rtl/rvfi_retire_sequencer_if.sv | 42 ++++
 rtl/rvfi_reorder_buf.sv | 46 ++++
 rtl/rvfi_retire_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rvfi_seq_pkg.sv
// rtl/rvfi_seq_pkg.sv - shared packet type, FSM states and slot helper for the retire sequencer
package rvfi_seq_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [63:0]     order;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [4:0]      rs1_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs2_rdata;
  } rvfi_pkt_t;

  typedef enum logic [1:0] {RUN, WAIT, HALT} seq_state_e;

  // Window slots are the low bits of the order; depth must be a power of two.
  function automatic int unsigned slot_of(input logic [63:0] order, input int unsigned depth);
    return order[31:0] & (depth - 1);
  endfunction

endpackage

// File: rtl/rvfi_retire_sequencer_if.sv
// rtl/rvfi_retire_sequencer_if.sv - multi-channel retirement input and sequenced output bundle
interface rvfi_retire_sequencer_if #(parameter int NRET = 2);
  import rvfi_seq_pkg::*;

  logic [NRET-1:0]      in_valid;
  logic [64*NRET-1:0]   in_order;
  logic [5*NRET-1:0]    in_rd_addr;
  logic [XLEN*NRET-1:0] in_rd_wdata;
  logic [5*NRET-1:0]    in_rs1_addr;
  logic [XLEN*NRET-1:0] in_rs1_rdata;
  logic [5*NRET-1:0]    in_rs2_addr;
  logic [XLEN*NRET-1:0] in_rs2_rdata;

  logic            out_valid;
  logic [63:0]     out_order;
  logic [4:0]      out_rd_addr;
  logic [XLEN-1:0] out_rd_wdata;
  logic [4:0]      out_rs1_addr;
  logic [XLEN-1:0] out_rs1_rdata;
  logic [4:0]      out_rs2_addr;
  logic [XLEN-1:0] out_rs2_rdata;
  logic            out_check;
  logic            done;
  logic            err_dup;
  logic            err_window;
  logic            err_timeout;

  modport master (
    output in_valid, in_order, in_rd_addr, in_rd_wdata, in_rs1_addr, in_rs1_rdata,
           in_rs2_addr, in_rs2_rdata,
    input  out_valid, out_order, out_rd_addr, out_rd_wdata, out_rs1_addr, out_rs1_rdata,
           out_rs2_addr, out_rs2_rdata, out_check, done, err_dup, err_window, err_timeout
  );

  modport slave (
    input  in_valid, in_order, in_rd_addr, in_rd_wdata, in_rs1_addr, in_rs1_rdata,
           in_rs2_addr, in_rs2_rdata,
    output out_valid, out_order, out_rd_addr, out_rd_wdata, out_rs1_addr, out_rs1_rdata,
           out_rs2_addr, out_rs2_rdata, out_check, done, err_dup, err_window, err_timeout
  );

endinterface

// File: rtl/rvfi_reorder_buf.sv
// rtl/rvfi_reorder_buf.sv - DEPTH-entry reorder window, NRET write ports, one read/free port at head
module rvfi_reorder_buf
  import rvfi_seq_pkg::*;
#(
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [NRET-1:0]                       wr_en,
  input  logic [NRET-1:0][$clog2(DEPTH)-1:0]    wr_slot,
  input  rvfi_pkt_t [NRET-1:0]                  wr_pkt,
  input  logic [$clog2(DEPTH)-1:0]              rd_slot,
  input  logic                                  rd_free,
  output rvfi_pkt_t                             rd_pkt,
  output logic                                  rd_valid,
  output logic [DEPTH-1:0]                      slot_valid
);

  rvfi_pkt_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;

  // Writes after the free so a slot vacated by the head can be refilled in the same cycle;
  // descending loop lets the lowest channel win a shared slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
    end else begin
      if (rd_free) vld[rd_slot] <= 1'b0;
      for (int c = NRET - 1; c >= 0; c--) begin
        if (wr_en[c]) vld[wr_slot[c]] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int c = NRET - 1; c >= 0; c--) begin
      if (wr_en[c]) mem[wr_slot[c]] <= wr_pkt[c];
    end
  end

  assign rd_pkt     = mem[rd_slot];
  assign rd_valid   = vld[rd_slot];
  assign slot_valid = vld;

endmodule

// File: rtl/rvfi_retire_sequencer.sv
// rtl/rvfi_retire_sequencer.sv - reorders multi-channel RVFI retirements into a single in-order stream
module rvfi_retire_sequencer
  import rvfi_seq_pkg::*;
#(
  parameter int          NRET        = 2,
  parameter int          DEPTH       = 8,
  parameter int          TIMEOUT     = 64,
  parameter logic [63:0] CHECK_ORDER = 64'd1000
) (
  input  logic                   clock,
  input  logic                   reset,
  rvfi_retire_sequencer_if.slave bus
);

  localparam int          SW      = $clog2(DEPTH);
  localparam logic [63:0] DEPTH64 = 64'(DEPTH);

  seq_state_e state_q, state_d;
  logic [63:0] head_q, win_hi;
  logic [31:0] timer_q, timer_d;
  logic [SW-1:0] head_slot;
  rvfi_pkt_t [NRET-1:0] in_pkt;
  logic [NRET-1:0] arr, in_win, hit_head, rep, occ, dup, win_err, wr_en;
  logic [NRET-1:0][SW-1:0] wr_slot;
  logic [DEPTH-1:0] slot_valid;
  rvfi_pkt_t buf_pkt, byp_pkt, emit_pkt, out_q;
  logic buf_valid, active, emit, nonempty, set_timeout;
  logic out_valid_q, out_check_q, done_q, err_dup_q, err_window_q, err_timeout_q;

  assign active    = (state_q != HALT);
  assign head_slot = SW'(slot_of(head_q, DEPTH));
  assign nonempty  = |slot_valid;

  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      in_pkt[c].order     = bus.in_order[64*c +: 64];
      in_pkt[c].rd_addr   = bus.in_rd_addr[5*c +: 5];
      in_pkt[c].rd_wdata  = bus.in_rd_wdata[XLEN*c +: XLEN];
      in_pkt[c].rs1_addr  = bus.in_rs1_addr[5*c +: 5];
      in_pkt[c].rs1_rdata = bus.in_rs1_rdata[XLEN*c +: XLEN];
      in_pkt[c].rs2_addr  = bus.in_rs2_addr[5*c +: 5];
      in_pkt[c].rs2_rdata = bus.in_rs2_rdata[XLEN*c +: XLEN];
      arr[c]              = active && bus.in_valid[c];
      hit_head[c]         = arr[c] && (in_pkt[c].order == head_q);
    end
  end

  // An emitting cycle widens the window by one so head+DEPTH can take the freed slot.
  assign emit   = active && (buf_valid || (|hit_head));
  assign win_hi = head_q + DEPTH64 + {63'd0, emit};

  always_comb begin
    rep     = '0;
    occ     = '0;
    dup     = '0;
    win_err = '0;
    wr_en   = '0;
    wr_slot = '0;
    in_win  = '0;
    for (int c = 0; c < NRET; c++) begin
      wr_slot[c] = SW'(slot_of(in_pkt[c].order, DEPTH));
      in_win[c]  = (in_pkt[c].order >= head_q) && (in_pkt[c].order < win_hi);
      for (int l = 0; l < c; l++) begin
        if (arr[l] && in_win[l] && (in_pkt[l].order == in_pkt[c].order)) rep[c] = 1'b1;
      end
      occ[c]     = slot_valid[wr_slot[c]] && (in_pkt[c].order != head_q + DEPTH64);
      win_err[c] = arr[c] && !in_win[c];
      dup[c]     = arr[c] && in_win[c] && (rep[c] || occ[c]);
      wr_en[c]   = arr[c] && in_win[c] && !rep[c] && !occ[c] && !hit_head[c];
    end
  end

  always_comb begin
    byp_pkt = in_pkt[0];
    for (int c = NRET - 1; c >= 0; c--) begin
      if (hit_head[c]) byp_pkt = in_pkt[c];
    end
    emit_pkt = buf_valid ? buf_pkt : byp_pkt;
  end

  rvfi_reorder_buf #(.NRET(NRET), .DEPTH(DEPTH)) u_buf (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_slot    (wr_slot),
    .wr_pkt     (in_pkt),
    .rd_slot    (head_slot),
    .rd_free    (emit),
    .rd_pkt     (buf_pkt),
    .rd_valid   (buf_valid),
    .slot_valid (slot_valid)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    set_timeout = 1'b0;
    case (state_q)
      RUN: begin
        if (nonempty && !emit) state_d = WAIT;
      end
      WAIT: begin
        if (emit || !nonempty) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == 32'(TIMEOUT - 1)) begin
          state_d     = HALT;
          set_timeout = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= RUN;
      timer_q       <= '0;
      head_q        <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      out_check_q   <= 1'b0;
      done_q        <= 1'b0;
      err_dup_q     <= 1'b0;
      err_window_q  <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      out_valid_q   <= emit;
      out_check_q   <= emit && (emit_pkt.order == CHECK_ORDER);
      done_q        <= done_q | out_check_q;
      err_dup_q     <= err_dup_q | (|dup);
      err_window_q  <= err_window_q | (|win_err);
      err_timeout_q <= err_timeout_q | set_timeout;
      if (emit) begin
        head_q <= head_q + 64'd1;
        out_q  <= emit_pkt;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_order     = out_q.order;
  assign bus.out_rd_addr   = out_q.rd_addr;
  assign bus.out_rd_wdata  = out_q.rd_wdata;
  assign bus.out_rs1_addr  = out_q.rs1_addr;
  assign bus.out_rs1_rdata = out_q.rs1_rdata;
  assign bus.out_rs2_addr  = out_q.rs2_addr;
  assign bus.out_rs2_rdata = out_q.rs2_rdata;
  assign bus.out_check     = out_check_q;
  assign bus.done          = done_q;
  assign bus.err_dup       = err_dup_q;
  assign bus.err_window    = err_window_q;
  assign bus.err_timeout   = err_timeout_q;

endmodule
